// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO device bus.
//   - controller state encodings (kept as 2-bit constants for legacy decode)
//   - MMIO address map anchors (upper half, UART window)
//   - default BUSY timeout and counter width
package mmio_pkg;

    localparam logic [1:0] MMIO_IDLE = 2'b00;
    localparam logic [1:0] MMIO_BUSY = 2'b01;
    localparam logic [1:0] MMIO_DONE = 2'b10;

    localparam logic [15:0] MMIO_BASE_HI   = 16'hFFFF;
    localparam logic [31:0] MMIO_UART_BASE = 32'hFFFF0120;
    localparam int          MMIO_UART_SIZE = 32;

    localparam int MMIO_TIMEOUT_DEF = 255;
    localparam int MMIO_CNT_W       = 8;

endpackage

// File: rtl/mmio_rdata_mux.sv
// mmio_rdata_mux: combinational response gather for the MMIO bus.
//   dev_work    in  N_DEV     per-slave claim
//   dev_done    in  N_DEV     per-slave done pulse
//   dev_rdata   in  32*N_DEV  per-slave read data, slave i at [32i+31:32i]
//   rdata       out 32        OR of the words whose done bit is set
//   no_claim    out 1         no slave claims the address
//   multi_claim out 1         more than one slave claims the address
module mmio_rdata_mux #(
    parameter int N_DEV = 4
) (
    input  logic [N_DEV-1:0]    dev_work,
    input  logic [N_DEV-1:0]    dev_done,
    input  logic [32*N_DEV-1:0] dev_rdata,
    output logic [31:0]         rdata,
    output logic                no_claim,
    output logic                multi_claim
);

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_DEV; i++) begin
            rdata = rdata | (dev_rdata[32*i +: 32] & {32{dev_done[i]}});
        end
    end

    assign no_claim    = ~|dev_work;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_claim = |(dev_work & (dev_work - N_DEV'(1)));

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: upstream master of the MMIO device bus.
// Accepts one CPU word access at a time, broadcasts it to all slaves, stalls
// the CPU until the single claiming slave pulses done, and returns read data
// or a bus error (no claim / multiple claims / optional timeout).
// Optional feature macro: MMIO_TIMEOUT_EN (BUSY abort after TIMEOUT cycles).
//   sys_clk, rst_n (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata        in   CPU access request
//   cpu_stall                                out  pipeline stall (combinational)
//   cpu_resp_valid/cpu_rdata/cpu_err         out  one-cycle response
//   mmio_read/mmio_write/mmio_addr/mmio_write_data  out  broadcast bus
//   dev_work/dev_done/dev_rdata              in   per-slave claim, done, data
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int N_DEV   = 4,
    parameter int TIMEOUT = MMIO_TIMEOUT_DEF
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_stall,
    output logic                cpu_resp_valid,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_err,
    output logic                mmio_read,
    output logic                mmio_write,
    output logic [31:0]         mmio_addr,
    output logic [31:0]         mmio_write_data,
    input  logic [N_DEV-1:0]    dev_work,
    input  logic [N_DEV-1:0]    dev_done,
    input  logic [32*N_DEV-1:0] dev_rdata
);

    logic [1:0]  state;
    logic [31:0] mux_rdata;
    logic        no_claim;
    logic        multi_claim;
    logic        timed_out;

    mmio_rdata_mux #(.N_DEV(N_DEV)) u_rdata_mux (
        .dev_work    (dev_work),
        .dev_done    (dev_done),
        .dev_rdata   (dev_rdata),
        .rdata       (mux_rdata),
        .no_claim    (no_claim),
        .multi_claim (multi_claim)
    );

`ifdef MMIO_TIMEOUT_EN
    localparam logic [MMIO_CNT_W-1:0] TO_LIM = MMIO_CNT_W'(TIMEOUT);
    logic [MMIO_CNT_W-1:0] cnt;

    // Held at zero while idle so every access starts counting from 0.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (state == MMIO_BUSY) cnt <= cnt + MMIO_CNT_W'(1);
        else                        cnt <= '0;
    end

    assign timed_out = (cnt == TO_LIM);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= MMIO_IDLE;
            mmio_read       <= 1'b0;
            mmio_write      <= 1'b0;
            mmio_addr       <= '0;
            mmio_write_data <= '0;
            cpu_resp_valid  <= 1'b0;
            cpu_err         <= 1'b0;
            cpu_rdata       <= '0;
        end else begin
            case (state)
                MMIO_IDLE: begin
                    if (cpu_req) begin
                        mmio_addr       <= cpu_addr;
                        mmio_write_data <= cpu_wdata;
                        mmio_read       <= !cpu_we;
                        mmio_write      <= cpu_we;
                        state           <= MMIO_BUSY;
                    end
                end
                MMIO_BUSY: begin
                    // Decode check outranks done: a done from a non-claiming
                    // slave must not be taken as a valid response.
                    if (no_claim || multi_claim || (dev_done == '0 && timed_out)) begin
                        cpu_rdata      <= '0;
                        cpu_err        <= 1'b1;
                        cpu_resp_valid <= 1'b1;
                        mmio_read      <= 1'b0;
                        mmio_write     <= 1'b0;
                        state          <= MMIO_DONE;
                    end else if (|dev_done) begin
                        cpu_rdata      <= mux_rdata;
                        cpu_err        <= 1'b0;
                        cpu_resp_valid <= 1'b1;
                        mmio_read      <= 1'b0;
                        mmio_write     <= 1'b0;
                        state          <= MMIO_DONE;
                    end
                end
                MMIO_DONE: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_err        <= 1'b0;
                    state          <= MMIO_IDLE;
                end
                default: state <= MMIO_IDLE;
            endcase
        end
    end

    assign cpu_stall = (state == MMIO_BUSY) || (state == MMIO_IDLE && cpu_req);

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed bench for mmio_bus_ctrl with four behavioural
// slaves (LEDs 0xFFFF0200, UART window, switches 0xFFFF0300, timers
// 0xFFFF0400) and a transaction-level model that predicts, per access, the
// response edge, error flag and read data; a compare process checks every
// cycle of each access against that prediction.
module tb_mmio_bus_ctrl;
    import mmio_pkg::*;

    localparam int N_DEV = 4;
    localparam int TO    = 5;

    logic                sys_clk = 1'b0;
    logic                rst_n   = 1'b0;
    logic                cpu_req = 1'b0;
    logic                cpu_we  = 1'b0;
    logic [31:0]         cpu_addr  = '0;
    logic [31:0]         cpu_wdata = '0;
    logic                cpu_stall, cpu_resp_valid, cpu_err;
    logic [31:0]         cpu_rdata;
    logic                mmio_read, mmio_write;
    logic [31:0]         mmio_addr, mmio_write_data;
    logic [N_DEV-1:0]    dev_work, dev_done;
    logic [32*N_DEV-1:0] dev_rdata;

    mmio_bus_ctrl #(.N_DEV(N_DEV), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data),
        .dev_work(dev_work), .dev_done(dev_done), .dev_rdata(dev_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- slaves ----------------
    logic dup = 1'b0;      // timers also claim the UART window
    logic hang = 1'b0;     // UART claims but never answers
    logic rogue_en = 1'b0; // switches pulse done without claiming

    function automatic logic [N_DEV-1:0] claims(input logic [31:0] a, input logic d);
        logic [N_DEV-1:0] c;
        logic [31:0] m;
        m = a & 32'hFFFF_FFE0;
        c[0] = (m == 32'hFFFF_0200);
        c[1] = (a >= MMIO_UART_BASE) && (a < MMIO_UART_BASE + 32'(MMIO_UART_SIZE));
        c[2] = (m == 32'hFFFF_0300);
        c[3] = (m == 32'hFFFF_0400) || (d && c[1]);
        return c;
    endfunction

    // Fixed register contents of each slave; UART word 0 reads as 1.
    function automatic logic [31:0] pattern(input int dev, input logic [2:0] idx);
        if (dev == 1 && idx == 3'd0) return 32'h0000_0001;
        return {8'(dev + 8'hA0), 16'h5A00, 5'd0, idx};
    endfunction

    logic [N_DEV-1:0] sdone;
    logic [31:0]      srd [N_DEV];
    logic [31:0]      last_wdata [N_DEV];
    int               wcount [N_DEV];

    assign dev_work = (mmio_read || mmio_write) ? claims(mmio_addr, dup) : '0;
    assign dev_done = sdone | ((rogue_en && (mmio_read || mmio_write)) ? 4'b0100 : 4'b0000);

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < N_DEV; i++) dev_rdata[32*i +: 32] = srd[i];
        if (rogue_en && (mmio_read || mmio_write)) dev_rdata[64 +: 32] = 32'hDEAD_BEEF;
    end

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sdone <= '0;
            for (int i = 0; i < N_DEV; i++) begin
                srd[i] <= '0; last_wdata[i] <= '0; wcount[i] <= 0;
            end
        end else begin
            for (int i = 0; i < N_DEV; i++) begin
                if (dev_work[i] && !sdone[i] && !(hang && i == 1)) begin
                    sdone[i] <= 1'b1;
                    srd[i]   <= mmio_read ? pattern(i, mmio_addr[4:2]) : 32'h0;
                    if (mmio_write) begin
                        last_wdata[i] <= mmio_write_data;
                        wcount[i]     <= wcount[i] + 1;
                    end
                end else begin
                    sdone[i] <= 1'b0;
                    srd[i]   <= '0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the access in flight: s = cycle the request is raised,
    // r = edge at which the response must appear.
    logic        active = 1'b0;
    int          s = 0, r = 0;
    logic        exp_we = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;

    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    int          got_cyc = 0;
    int          resp_cnt = 0;

    initial forever begin
        @(negedge sys_clk);
        #3;
        if (cpu_resp_valid) begin
            got_rdata = cpu_rdata; got_err = cpu_err; got_cyc = cyc; resp_cnt++;
        end
        if (active && cyc >= s && cyc <= r + 1) begin
            chk1("stall", cpu_stall, cyc < r);
            chk1("resp_valid", cpu_resp_valid, cyc == r);
            chk1("mmio_read", mmio_read, !exp_we && cyc > s && cyc < r);
            chk1("mmio_write", mmio_write, exp_we && cyc > s && cyc < r);
            if (cyc > s) begin
                chk32("mmio_addr", mmio_addr, exp_addr);
                chk32("mmio_write_data", mmio_write_data, exp_wdata);
            end
            if (cyc == r) begin
                chk1("cpu_err", cpu_err, exp_err);
                chk32("cpu_rdata", cpu_rdata, exp_rdata);
            end
            if (cyc == r + 1) begin
                chk1("cpu_err_clear", cpu_err, 1'b0);
                chk32("cpu_rdata_hold", cpu_rdata, exp_rdata);
            end
        end
    end

    // Issue one access, predict its outcome, and follow it for at most
    // 'limit' cycles. A completed access drops cpu_req in the DONE cycle.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int limit);
        logic [N_DEV-1:0] c;
        int k;
        @(negedge sys_clk); #1;
        c = claims(addr, dup);
        s = cyc; exp_we = we; exp_addr = addr; exp_wdata = wdata;
        if ($countones(c) != 1) begin
            r = s + 2; exp_err = 1'b1; exp_rdata = '0;
        end else if (hang && c[1]) begin
`ifdef MMIO_TIMEOUT_EN
            r = s + TO + 2;
`else
            r = s + 1_000_000;
`endif
            exp_err = 1'b1; exp_rdata = '0;
        end else begin
            k = 0;
            for (int i = 0; i < N_DEV; i++) if (c[i]) k = i;
            r = s + 3; exp_err = 1'b0;
            exp_rdata = we ? 32'h0 : pattern(k, addr[4:2]);
        end
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        active = 1'b1;
        while (cyc < r && cyc < s + limit) begin
            @(negedge sys_clk); #1;
        end
        if (cyc == r) begin
            cpu_req = 1'b0;
            @(negedge sys_clk); #1;
            @(negedge sys_clk); #1;
            active = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        active = 1'b0;
        cpu_req = 1'b0;
        rst_n = 1'b0;
        @(negedge sys_clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int wc_before;

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        #1;
        chk1("rst_read", mmio_read, 1'b0);
        chk1("rst_write", mmio_write, 1'b0);
        chk1("rst_resp", cpu_resp_valid, 1'b0);
        chk1("rst_err", cpu_err, 1'b0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk32("rst_rdata", cpu_rdata, 32'h0);
        chk32("rst_addr", mmio_addr, 32'h0);
        chk32("rst_wdata", mmio_write_data, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // UART read: slave 1 returns 1, response at edge 3
        access(1'b0, 32'hFFFF_0120, 32'h0, 20);
        chk32("lit_uart_rdata", got_rdata, 32'h0000_0001);
        chk1("lit_uart_err", got_err, 1'b0);
        chk32("lit_uart_latency", 32'(got_cyc - s), 32'd3);

        // UART write 0x41: single done pulse, data seen by slave
        wc_before = wcount[1];
        access(1'b1, 32'hFFFF_0134, 32'h0000_0041, 20);
        chk32("lit_write_count", 32'(wcount[1] - wc_before), 32'd1);
        chk32("lit_write_data", last_wdata[1], 32'h0000_0041);
        chk32("lit_write_bus_data", mmio_write_data, 32'h0000_0041);

        // Other slaves
        access(1'b0, 32'hFFFF_0208, 32'h0, 20);
        chk32("lit_led_rdata", got_rdata, 32'hA05A_0002);
        access(1'b1, 32'hFFFF_0300, 32'h1234_5678, 20);
        access(1'b0, 32'hFFFF_041C, 32'h0, 20);

        // Unclaimed address: error at edge 2
        access(1'b0, 32'hFFFF_0000, 32'h0, 20);
        chk1("lit_noclaim_err", got_err, 1'b1);
        chk32("lit_noclaim_rdata", got_rdata, 32'h0);
        chk32("lit_noclaim_latency", 32'(got_cyc - s), 32'd2);

        // Two claimants
        dup = 1'b1;
        access(1'b0, 32'hFFFF_0124, 32'h0, 20);
        chk1("lit_multi_err", got_err, 1'b1);
        dup = 1'b0;

        // Done from a non-claiming slave: decode error wins
        rogue_en = 1'b1;
        access(1'b0, 32'hFFFF_0000, 32'h0, 20);
        chk1("lit_rogue_err", got_err, 1'b1);
        chk32("lit_rogue_rdata", got_rdata, 32'h0);
        rogue_en = 1'b0;

        // Back-to-back request held high into the next IDLE
        access(1'b0, 32'hFFFF_0128, 32'h0, 20);

        // Hung slave
        hang = 1'b1;
`ifdef MMIO_TIMEOUT_EN
        access(1'b0, 32'hFFFF_0120, 32'h0, 40);
        chk1("lit_timeout_err", got_err, 1'b1);
        chk32("lit_timeout_latency", 32'(got_cyc - s), 32'(TO + 2));
`else
        wc_before = resp_cnt;
        access(1'b0, 32'hFFFF_0120, 32'h0, 1000);
        chk1("lit_hang_stall", cpu_stall, 1'b1);
        chk32("lit_hang_no_resp", 32'(resp_cnt - wc_before), 32'd0);
        pulse_reset();
`endif

        // Reset in the middle of BUSY
        @(negedge sys_clk); #1;
        cpu_we = 1'b0; cpu_addr = 32'hFFFF_0120; cpu_req = 1'b1;
        repeat (2) begin @(negedge sys_clk); #1; end
        chk1("lit_busy_read", mmio_read, 1'b1);
        wc_before = resp_cnt;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk1("async_rst_read", mmio_read, 1'b0);
        chk1("async_rst_resp", cpu_resp_valid, 1'b0);
        chk1("async_rst_stall", cpu_stall, 1'b0);
        @(negedge sys_clk); #1;
        rst_n = 1'b1;
        hang = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk32("rst_no_resp", 32'(resp_cnt - wc_before), 32'd0);

        // Normal access after reset
        access(1'b0, 32'hFFFF_0120, 32'h0, 20);
        chk32("lit_post_rst_rdata", got_rdata, 32'h0000_0001);

        repeat (2) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Upstream master for the MMIO device bus. Takes one word access at a time from the CPU memory stage and broadcasts it to all MMIO slaves: UART at 0xFFFF0120–0xFFFF013F, plus LEDs, switches and timers.
- Holds the CPU stalled until the claiming slave pulses done. Returns read data and detects unclaimed or multiply-claimed addresses.
- Owns the request/withdraw timing that slaves depend on. Slaves register done one edge after seeing a request and must see the request dropped at the following edge.

Parameters:
- N_DEV, 4, number of slave ports.
- TIMEOUT, 255, maximum number of BUSY cycles before a claimed access is aborted. Used only with MMIO_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  reset
- cpu_req  in  1  MMIO access request, level, held until cpu_resp_valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address, upper half 0xFFFF
- cpu_wdata  in  32  store data
- cpu_stall  out  1  stall the pipeline
- cpu_resp_valid  out  1  one-cycle pulse, response present
- cpu_rdata  out  32  load data, valid with cpu_resp_valid
- cpu_err  out  1  bus error, valid with cpu_resp_valid
- mmio_read  out  1  broadcast read strobe
- mmio_write  out  1  broadcast write strobe
- mmio_addr  out  32  broadcast address
- mmio_write_data  out  32  broadcast write data
- dev_work  in  N_DEV  per-slave claim, combinational from mmio_* inputs
- dev_done  in  N_DEV  per-slave done pulse
- dev_rdata  in  32*N_DEV  per-slave read data, slave i at [32i+31:32i]; zero when not done

Behaviour:
Reset and interface conventions:
- Reset rst_n, asynchronous, active-low; clock sys_clk.
- Reset values: state IDLE; mmio_read, mmio_write, cpu_resp_valid and cpu_err = 0; mmio_addr, mmio_write_data and cpu_rdata = 0.
- A reset mid-access drops the strobes immediately and emits no response.

State machine: IDLE, BUSY, DONE; all outputs registered except cpu_stall.
- IDLE, cpu_req=1: latch cpu_addr and cpu_wdata into mmio_addr and mmio_write_data.
  - Set mmio_read = !cpu_we and mmio_write = cpu_we.
  - Clear the timeout counter and go to BUSY.
- BUSY, evaluated every edge in this priority:
  1. dev_work has zero bits or more than one bit set: error exit.
  2. dev_done has any bit set: success exit.
  3. Counter reaches TIMEOUT (MMIO_TIMEOUT_EN only): error exit.
  4. Otherwise stay in BUSY and increment the counter.
- Success exit: cpu_rdata = OR of the dev_rdata words masked by dev_done; cpu_err = 0.
- Error exit: cpu_rdata = 0; cpu_err = 1.
- Every exit drops mmio_read and mmio_write at that same edge, sets cpu_resp_valid = 1 and goes to DONE.
- DONE: clear cpu_resp_valid and cpu_err; cpu_rdata holds. Always go to IDLE; cpu_req is ignored in DONE.

Stall and handshake:
- cpu_stall = (state==BUSY) || (state==IDLE && cpu_req). It is low during DONE so the CPU consumes the response.
- The CPU drops cpu_req in the DONE cycle; a cpu_req still high in the following IDLE is a new access.
- mmio_addr and mmio_write_data hold stable for the whole of BUSY and keep their value after the exit.

Latency:
- Request in cycle 0 → strobe at edge 1 → slave done at edge 2 → cpu_resp_valid high from edge 3 to edge 4.
- Minimum 4 cycles per access; at most one access is in flight.

Boundary conditions:
- A slave that asserts done while its work is already low is reported as an error: the decode check has priority.
- TIMEOUT=0 combined with MMIO_TIMEOUT_EN aborts on the first BUSY cycle that has no done.

Optional Feature:
MMIO_TIMEOUT_EN:
- Defined: 8-bit counter with the TIMEOUT abort as described; a hung slave yields cpu_err.
- Undefined: no counter; BUSY waits indefinitely for done, and only decode errors exit early.

Decomposition:
- Package mmio_pkg holds:
  - state encodings MMIO_IDLE=2'b00, MMIO_BUSY=2'b01, MMIO_DONE=2'b10;
  - MMIO_BASE_HI=16'hFFFF;
  - UART window base 32'hFFFF0120, size 32;
  - TIMEOUT default.
- Sub-module mmio_rdata_mux: combinational onehot AND-OR of dev_rdata by dev_done, plus the zero/multi-claim flags from dev_work.

Test Plan:
- Read 0xFFFF0120, slave 1 claims and pulses done with data 0x00000001 → cpu_resp_valid at edge 3, cpu_rdata=0x00000001, cpu_err=0, mmio_read low at edge 3.
- Write 0xFFFF0134 with data 0x41 → mmio_write high exactly edges 1–3 and mmio_write_data=0x00000041; slave sees a single write (one done pulse).
- Read 0xFFFF0000, no slave claims → cpu_resp_valid at edge 2 with cpu_err=1 and cpu_rdata=0; stall released.
- Two slaves claim 0xFFFF0124 → cpu_err=1 and no mmio strobe after edge 2.
- With MMIO_TIMEOUT_EN and TIMEOUT=5, slave claims but never pulses done → cpu_err after 6 BUSY cycles. Without the macro, stall persists for 1000 cycles.
- rst_n pulsed low mid-BUSY → mmio_read=0 asynchronously and no cpu_resp_valid; the next request completes normally.
